// File: rtl/scalar_mat_pkg.sv
// Shared types and helpers for the scalar x matrix scale sequencer.
//   state_t   : sequencer FSM states (idle, streaming reads, draining writes, done pulse)
//   addr_w()  : element-index width for an a x b matrix (at least 1 bit)
//   sat_hi()  : most positive n-bit signed value, zero-extended to 64 bits
//   sat_lo()  : most negative n-bit signed value; only its low n bits are meaningful
package scalar_mat_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StDone
   } state_t;

   function automatic int unsigned addr_w(input int unsigned a, input int unsigned b);
      int unsigned n;
      n = a * b;
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [63:0] sat_hi(input int unsigned n);
      return (64'd1 << (n - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] sat_lo(input int unsigned n);
      return ~sat_hi(n);
   endfunction

endpackage

// File: rtl/fxp_mul_fit.sv
// Combinational signed fixed-point multiply with result fitting.
//   a, b   in  N_BITS  signed two's complement operands
//   res    out N_BITS  (a*b) >>> FRAC_BITS fitted to N_BITS
//   ovf    out 1       shifted product lies outside the N_BITS signed range
// Build option SCALE_SAT_EN: when defined, out-of-range results clamp to the signed
// limits; otherwise the low N_BITS of the shifted product are returned (wrap).
module fxp_mul_fit
   import scalar_mat_pkg::*;
#(
   parameter int unsigned N_BITS    = 22,
   parameter int unsigned FRAC_BITS = 0
) (
   input  logic [N_BITS-1:0] a,
   input  logic [N_BITS-1:0] b,
   output logic [N_BITS-1:0] res,
   output logic              ovf
);

`ifdef SCALE_SAT_EN
   localparam logic [N_BITS-1:0] SatHi = N_BITS'(sat_hi(N_BITS));
   localparam logic [N_BITS-1:0] SatLo = N_BITS'(sat_lo(N_BITS));
`endif

   logic signed [2*N_BITS-1:0] a_ext;
   logic signed [2*N_BITS-1:0] b_ext;
   logic signed [2*N_BITS-1:0] prod;
   logic signed [2*N_BITS-1:0] shifted;
   logic        [N_BITS:0]     hi;

   always_comb begin
      a_ext   = {{N_BITS{a[N_BITS-1]}}, a};
      b_ext   = {{N_BITS{b[N_BITS-1]}}, b};
      // Low 2*N_BITS bits of the extended product equal the exact signed product.
      prod    = a_ext * b_ext;
      shifted = prod >>> FRAC_BITS;
      // The value fits iff every bit from the N_BITS sign position upward agrees.
      hi      = shifted[2*N_BITS-1:N_BITS-1];
      ovf     = !((hi == '0) || (hi == '1));
`ifdef SCALE_SAT_EN
      if (ovf) begin
         res = shifted[2*N_BITS-1] ? SatLo : SatHi;
      end else begin
         res = shifted[N_BITS-1:0];
      end
`else
      res = shifted[N_BITS-1:0];
`endif
   end

endmodule

// File: rtl/scalar_mat_scale_seq.sv
// Scalar x matrix scale sequencer. Streams a SIZE_A x SIZE_B row-major matrix from a source
// RAM through one shared fixed-point multiplier into a result RAM, one element per cycle,
// with backpressure from the result RAM.
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start, abort      1-cycle request (taken only when idle) / cancel current operation
//   scale             scalar, latched when a start is accepted
//   busy, done        high while streaming / 1-cycle pulse after the last write
//   rd_en, rd_addr    source RAM read strobe and element index (data returns next cycle)
//   rd_data           source element; RAM holds it while rd_en is low
//   wr_en, wr_addr    result RAM write strobe and element index
//   wr_data           scaled element
//   wr_ready          result RAM accepts the write when wr_en && wr_ready
//   ovf               sticky out-of-range flag, cleared when a start is accepted
// Build option SCALE_SAT_EN selects saturating (defined) or wrapping (undefined) results.
// Pipeline: S0 issues the read, S1 multiplies the returned data, S2 presents the write.
// A refused write freezes all three stages.
module scalar_mat_scale_seq
   import scalar_mat_pkg::*;
#(
   parameter int unsigned  SIZE_A    = 8,
   parameter int unsigned  SIZE_B    = 8,
   parameter int unsigned  N_BITS    = 22,
   parameter int unsigned  FRAC_BITS = 0,
   localparam int unsigned ADDR_W    = addr_w(SIZE_A, SIZE_B)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [N_BITS-1:0] scale,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [N_BITS-1:0] rd_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [N_BITS-1:0] wr_data,
   input  logic              wr_ready,
   output logic              ovf
);

   localparam int unsigned       NumElem  = SIZE_A * SIZE_B;
   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NumElem - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
   logic [N_BITS-1:0] scale_q, scale_d;
   logic              v1_q, v1_d;
   logic              v2_q, v2_d;
   logic [ADDR_W-1:0] a1_q, a1_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [N_BITS-1:0] wr_data_q, wr_data_d;
   logic              ovf_q, ovf_d;

   logic              stall;
   logic              issue;
   logic              last_wr;
   logic [N_BITS-1:0] fit_res;
   logic              fit_ovf;

   fxp_mul_fit #(
      .N_BITS    (N_BITS),
      .FRAC_BITS (FRAC_BITS)
   ) u_mul (
      .a   (rd_data),
      .b   (scale_q),
      .res (fit_res),
      .ovf (fit_ovf)
   );

   always_comb begin
      stall   = v2_q && !wr_ready;
      issue   = (state_q == StRun) && !stall;
      last_wr = v2_q && wr_ready && (wr_addr_q == LastAddr);
   end

   always_comb begin
      state_d   = state_q;
      rd_cnt_d  = rd_cnt_q;
      scale_d   = scale_q;
      v1_d      = v1_q;
      v2_d      = v2_q;
      a1_d      = a1_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      ovf_d     = ovf_q;

      // Pipeline advance; everything holds while the result RAM refuses the write.
      if (!stall) begin
         v1_d = issue;
         if (issue) begin
            a1_d = rd_cnt_q;
         end
         v2_d = v1_q;
         if (v1_q) begin
            wr_addr_d = a1_q;
            wr_data_d = fit_res;
            if (fit_ovf) begin
               ovf_d = 1'b1;
            end
         end
      end

      // Counter parks on the last index so no read past the matrix is ever issued.
      if (issue && (rd_cnt_q != LastAddr)) begin
         rd_cnt_d = rd_cnt_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (start && !abort) begin
               state_d  = StRun;
               scale_d  = scale;
               ovf_d    = 1'b0;
               rd_cnt_d = '0;
            end
         end
         StRun: begin
            if (abort) begin
               state_d = StIdle;
               v1_d    = 1'b0;
               v2_d    = 1'b0;
            end else if (issue && (rd_cnt_q == LastAddr)) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (abort) begin
               state_d = StIdle;
               v1_d    = 1'b0;
               v2_d    = 1'b0;
            end else if (last_wr) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         rd_cnt_q  <= '0;
         scale_q   <= '0;
         v1_q      <= 1'b0;
         v2_q      <= 1'b0;
         a1_q      <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_cnt_q  <= rd_cnt_d;
         scale_q   <= scale_d;
         v1_q      <= v1_d;
         v2_q      <= v2_d;
         a1_q      <= a1_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         ovf_q     <= ovf_d;
      end
   end

   always_comb begin
      busy    = (state_q == StRun) || (state_q == StDrain);
      done    = (state_q == StDone);
      rd_en   = issue;
      rd_addr = rd_cnt_q;
      wr_en   = v2_q;
      wr_addr = wr_addr_q;
      wr_data = wr_data_q;
      ovf     = ovf_q;
   end

endmodule

// File: tb/tb_scalar_mat_scale_seq.sv
// Bench for scalar_mat_scale_seq: two 2x2 instances pinned with hand-computed literals,
// and one 8x8 instance checked every cycle against a behavioural scoreboard.
`timescale 1ns/1ps
module tb_scalar_mat_scale_seq;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // (e*s) >>> frac, fitted to 22 bits by plain integer arithmetic.
   function automatic logic [21:0] model_fit(input logic [21:0] e, input logic [21:0] s,
                                             input int frac);
      longint p;
      p = (longint'($signed(e)) * longint'($signed(s))) >>> frac;
`ifdef SCALE_SAT_EN
      if (p > 64'sd2097151) p = 64'sd2097151;
      else if (p < -64'sd2097152) p = -64'sd2097152;
`endif
      return p[21:0];
   endfunction

   // ---------------- instance A: 2x2, FRAC_BITS=0 ----------------
   logic        a_start, a_abort, a_busy, a_done, a_rd_en, a_wr_en, a_wr_ready, a_ovf;
   logic [21:0] a_scale, a_rd_data, a_wr_data;
   logic [1:0]  a_rd_addr, a_wr_addr;
   logic [21:0] a_mem [4];
   logic [21:0] a_got [4];
   int          a_dones;

   scalar_mat_scale_seq #(.SIZE_A(2), .SIZE_B(2), .N_BITS(22), .FRAC_BITS(0)) u_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort), .scale(a_scale),
      .busy(a_busy), .done(a_done), .rd_en(a_rd_en), .rd_addr(a_rd_addr),
      .rd_data(a_rd_data), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
      .wr_ready(a_wr_ready), .ovf(a_ovf)
   );
   always @(posedge clk) if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];

   // ---------------- instance B: 2x2, FRAC_BITS=8 ----------------
   logic        b_start, b_abort, b_busy, b_done, b_rd_en, b_wr_en, b_wr_ready, b_ovf;
   logic [21:0] b_scale, b_rd_data, b_wr_data;
   logic [1:0]  b_rd_addr, b_wr_addr;
   logic [21:0] b_mem [4];
   logic [21:0] b_got [4];
   int          b_dones;

   scalar_mat_scale_seq #(.SIZE_A(2), .SIZE_B(2), .N_BITS(22), .FRAC_BITS(8)) u_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .scale(b_scale),
      .busy(b_busy), .done(b_done), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
      .rd_data(b_rd_data), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
      .wr_ready(b_wr_ready), .ovf(b_ovf)
   );
   always @(posedge clk) if (b_rd_en) b_rd_data <= b_mem[b_rd_addr];

   // ---------------- instance C: 8x8, FRAC_BITS=0 ----------------
   logic        c_start, c_abort, c_busy, c_done, c_rd_en, c_wr_en, c_wr_ready, c_ovf;
   logic [21:0] c_scale, c_rd_data, c_wr_data;
   logic [5:0]  c_rd_addr, c_wr_addr;
   logic [21:0] c_mem [64];

   scalar_mat_scale_seq #(.SIZE_A(8), .SIZE_B(8), .N_BITS(22), .FRAC_BITS(0)) u_c (
      .clk(clk), .rst_n(rst_n), .start(c_start), .abort(c_abort), .scale(c_scale),
      .busy(c_busy), .done(c_done), .rd_en(c_rd_en), .rd_addr(c_rd_addr),
      .rd_data(c_rd_data), .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
      .wr_ready(c_wr_ready), .ovf(c_ovf)
   );
   always @(posedge clk) if (c_rd_en) c_rd_data <= c_mem[c_rd_addr];

   // Scoreboard for C: the run is a sequence of 64 reads and 64 writes in index order,
   // each write carrying fit(mem[k] * scale latched at start).
   bit          model_active = 1'b0;
   logic [21:0] m_scale;
   int          m_next_rd, m_next_wr, m_writes;
   bit          prev_stall = 1'b0;
   logic [5:0]  prev_addr;
   logic [21:0] prev_data;

   task automatic c_start_run(input logic [21:0] sc);
      c_scale      = sc;
      c_start      = 1'b1;
      m_scale      = sc;
      m_next_rd    = 0;
      m_next_wr    = 0;
      m_writes     = 0;
      model_active = 1'b1;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (!model_active) begin
               check("c_quiet_when_idle", {c_rd_en, c_wr_en, c_done}, 3'b000);
            end else begin
               if (prev_stall) begin
                  check("c_stall_hold", {c_wr_en, c_wr_addr, c_wr_data},
                        {1'b1, prev_addr, prev_data});
               end
               if (c_rd_en) begin
                  check("c_rd_in_stall", c_wr_en && !c_wr_ready, 1'b0);
                  check("c_rd_addr", c_rd_addr, m_next_rd);
                  m_next_rd++;
               end
               if (c_wr_en && c_wr_ready) begin
                  check("c_wr_addr", c_wr_addr, m_next_wr);
                  check("c_wr_data", c_wr_data, model_fit(c_mem[m_next_wr % 64], m_scale, 0));
                  m_next_wr++;
                  m_writes++;
               end
               if (c_done) begin
                  check("c_done_after_all", m_writes, 64);
                  model_active = 1'b0;
               end
            end
            prev_stall = c_wr_en && !c_wr_ready;
            prev_addr  = c_wr_addr;
            prev_data  = c_wr_data;
         end
      end
   end

   task automatic run_a(input logic [21:0] sc);
      for (int i = 0; i < 4; i++) a_got[i] = '0;
      a_dones = 0;
      a_scale = sc;
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (a_wr_en) a_got[a_wr_addr] = a_wr_data;
         if (a_done) a_dones++;
         tick();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

   initial begin
      logic [21:0] exp_a [4];
      logic [21:0] exp_b [4];
      logic [21:0] exp_ovf [4];
      int          cycle, done_at, c_dones;
      bit          got;

      rst_n = 1'b0;
      a_start = 1'b0; a_abort = 1'b0; a_scale = '0; a_wr_ready = 1'b1;
      b_start = 1'b0; b_abort = 1'b0; b_scale = '0; b_wr_ready = 1'b1;
      c_start = 1'b0; c_abort = 1'b0; c_scale = '0; c_wr_ready = 1'b1;
      c_rd_data = '0;
      for (int i = 0; i < 64; i++) c_mem[i] = 22'(i * 1237 - 40000);

      #2;
      check("c_reset_outs", {c_busy, c_done, c_rd_en, c_wr_en, c_ovf, c_rd_addr, c_wr_addr,
                             c_wr_data}, 0);
      check("a_reset_outs", {a_busy, a_done, a_rd_en, a_wr_en, a_ovf, a_rd_addr, a_wr_addr,
                             a_wr_data}, 0);
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // A: cycle-exact 2x2 stream, scale 3, mem {1,2,-3,4}.
      a_mem = '{22'd1, 22'd2, 22'h3FFFFD, 22'd4};
      exp_a = '{22'd3, 22'd6, 22'h3FFFF7, 22'd12};
      a_scale = 22'd3;
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         check("a_rd_en", a_rd_en, (c >= 1 && c <= 4));
         if (c <= 4) check("a_rd_addr", a_rd_addr, c - 1);
         check("a_wr_en", a_wr_en, (c >= 3 && c <= 6));
         if (c >= 3 && c <= 6) begin
            check("a_wr_addr", a_wr_addr, c - 3);
            check("a_wr_data", a_wr_data, exp_a[c-3]);
         end
         check("a_done", a_done, c == 7);
         check("a_busy", a_busy, c <= 6);
         tick();
      end

      // A: overflow case, scale 2^20 with elements {4,1,-1,0}.
      a_mem = '{22'd4, 22'd1, 22'h3FFFFF, 22'd0};
`ifdef SCALE_SAT_EN
      exp_ovf = '{22'h1FFFFF, 22'h100000, 22'h300000, 22'd0};
`else
      exp_ovf = '{22'h000000, 22'h100000, 22'h300000, 22'd0};
`endif
      run_a(22'h100000);
      for (int i = 0; i < 4; i++) check("a_ovf_data", a_got[i], exp_ovf[i]);
      check("a_ovf_flag", a_ovf, 1'b1);
      check("a_ovf_done", a_dones, 1);
      // ovf clears as soon as the next start is accepted.
      a_scale = 22'd1;
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      @(negedge clk);
      check("a_ovf_clear", {a_ovf, a_busy}, 2'b01);
      repeat (10) tick();

      // B: FRAC_BITS=8, scale 0.5.
      b_mem = '{22'h200, 22'h3FFE00, 22'h100, 22'h7FF};
      exp_b = '{22'h100, 22'h3FFF00, 22'h080, 22'h3FF};
      for (int i = 0; i < 4; i++) b_got[i] = '0;
      b_dones = 0;
      b_scale = 22'h80;
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (b_wr_en) b_got[b_wr_addr] = b_wr_data;
         if (b_done) b_dones++;
         tick();
      end
      for (int i = 0; i < 4; i++) check("b_frac_data", b_got[i], exp_b[i]);
      check("b_frac_ovf", b_ovf, 1'b0);
      check("b_frac_done", b_dones, 1);

      // C: 8x8 run, write stall on cycles 10..12, ignored start at cycle 20 and at done.
      c_start_run(22'd5);
      tick();
      c_start = 1'b0;
      cycle = 1;
      got = 1'b0;
      done_at = 0;
      while (!got && cycle < 200) begin
         c_wr_ready = !(cycle >= 10 && cycle <= 12);
         c_start    = (cycle == 20);
         c_scale    = (cycle == 20) ? 22'd99 : 22'd5;
         @(negedge clk);
         if (c_done) begin
            got     = 1'b1;
            done_at = cycle;
            c_start = 1'b1;
            c_scale = 22'd77;
         end else begin
            tick();
            cycle++;
         end
      end
      tick();
      c_start = 1'b0;
      c_wr_ready = 1'b1;
      @(negedge clk);
      check("c_done_seen", got, 1'b1);
      check("c_done_cycle", done_at, 70);
      check("c_start_at_done_ignored", {c_busy, c_rd_en}, 2'b00);
      check("c_writes_total", m_writes, 64);
      check("c_ovf_clean", c_ovf, 1'b0);
      repeat (3) tick();

      // C: abort at cycle 4.
      c_start_run(22'd3);
      tick();
      c_start = 1'b0;
      repeat (3) tick();
      c_abort = 1'b1;
      tick();
      c_abort = 1'b0;
      model_active = 1'b0;
      @(negedge clk);
      check("c_abort_outs", {c_busy, c_rd_en, c_wr_en, c_done}, 4'b0000);
      check("c_abort_reads", m_next_rd, 4);
      check("c_abort_writes", m_writes, 2);
      c_dones = 0;
      repeat (80) begin
         @(negedge clk);
         if (c_done) c_dones++;
         tick();
      end
      check("c_abort_no_done", c_dones, 0);

      // C: start and abort together in idle.
      c_scale = 22'd9;
      c_start = 1'b1;
      c_abort = 1'b1;
      tick();
      c_start = 1'b0;
      c_abort = 1'b0;
      @(negedge clk);
      check("c_start_abort_idle", {c_busy, c_rd_en}, 2'b00);
      repeat (5) tick();

      // C: asynchronous reset mid-run.
      c_start_run(22'd2);
      tick();
      c_start = 1'b0;
      repeat (9) tick();
      #3;
      rst_n = 1'b0;
      model_active = 1'b0;
      #1;
      check("c_async_reset", {c_busy, c_done, c_rd_en, c_wr_en, c_ovf, c_rd_addr, c_wr_addr,
                              c_wr_data}, 0);
      tick();
      check("c_reset_held", {c_busy, c_rd_en, c_wr_en}, 3'b000);
      tick();
      rst_n = 1'b1;
      repeat (20) tick();
      @(negedge clk);
      check("c_after_reset_idle", {c_busy, c_done}, 2'b00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
